// File: rtl/riscv_mem_arbiter_if.sv
// One requester port of riscv_mem_arbiter (request fields, accept strobe, response).
// master = requester side, slave = arbiter side.
interface riscv_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic              we;
  logic [3:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Two-requester (CPU / UART programmer) arbiter for the shared data-memory port, one transaction
// in flight. Define MEM_ARB_RR_EN for round-robin; otherwise UPG has fixed priority over CPU.
module riscv_mem_arbiter #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_upg_active,
  riscv_mem_arbiter_if.slave        io_cpu,
  riscv_mem_arbiter_if.slave        io_upg,
  output logic                      o_mem_en,
  output logic                      o_mem_we,
  output logic [3:0]                o_mem_be,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [DATA_W-1:0]         o_mem_wdata,
  input  logic [DATA_W-1:0]         i_mem_rdata
);

  localparam logic [2:0] LatInit = 3'(MEM_LAT);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e     r_state;
  logic [2:0] r_cnt;
  logic       r_owner_upg;
  logic       r_cpu_rvalid;
  logic       r_upg_rvalid;
`ifdef MEM_ARB_RR_EN
  logic       r_rr_last_upg;
`endif

  logic w_elig_cpu;
  logic w_elig_upg;
  logic w_win_upg;
  logic w_grant;

  always_comb begin
    w_elig_upg = io_upg.req;
    w_elig_cpu = io_cpu.req & ~i_upg_active;
`ifdef MEM_ARB_RR_EN
    // On a tie the side that did not win last time gets the port.
    w_win_upg  = w_elig_upg & (~w_elig_cpu | ~r_rr_last_upg);
`else
    w_win_upg  = w_elig_upg;
`endif
    // Gated by reset so nothing is accepted while the block is held in reset.
    w_grant    = i_rst_n & (r_state == StIdle) & (w_elig_cpu | w_elig_upg);
  end

  always_comb begin
    o_mem_en     = w_grant;
    o_mem_we     = w_grant & (w_win_upg ? io_upg.we : io_cpu.we);
    o_mem_be     = w_win_upg ? io_upg.be    : io_cpu.be;
    o_mem_addr   = w_win_upg ? io_upg.addr  : io_cpu.addr;
    o_mem_wdata  = w_win_upg ? io_upg.wdata : io_cpu.wdata;
    io_cpu.ready  = w_grant & ~w_win_upg;
    io_upg.ready  = w_grant & w_win_upg;
    io_cpu.rvalid = r_cpu_rvalid;
    io_upg.rvalid = r_upg_rvalid;
    io_cpu.rdata  = i_mem_rdata;
    io_upg.rdata  = i_mem_rdata;
  end

  // rvalid is registered one cycle ahead so it is high exactly while r_cnt == 1 in StBusy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_cnt         <= 3'd0;
      r_owner_upg   <= 1'b0;
      r_cpu_rvalid  <= 1'b0;
      r_upg_rvalid  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_rr_last_upg <= 1'b1;
`endif
    end else begin
      r_cpu_rvalid <= 1'b0;
      r_upg_rvalid <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_grant) begin
            r_owner_upg   <= w_win_upg;
            r_cnt         <= LatInit;
            r_state       <= StBusy;
`ifdef MEM_ARB_RR_EN
            r_rr_last_upg <= w_win_upg;
`endif
            if (LatInit == 3'd1) begin
              r_cpu_rvalid <= ~w_win_upg;
              r_upg_rvalid <= w_win_upg;
            end
          end
        end
        StBusy: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd2) begin
            r_cpu_rvalid <= ~r_owner_upg;
            r_upg_rvalid <= r_owner_upg;
          end
          if (r_cnt == 3'd1) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: directed scenarios plus random traffic, all checked
// against a cycle-count reference model (grant time, response time, arbitration policy).
module tb_riscv_mem_arbiter;
  localparam int unsigned AW  = 14;
  localparam int unsigned DW  = 32;
  localparam int          LAT = 3;

  typedef struct packed {
    logic          req;
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic upg_active = 1'b0;
  logic upg_active1 = 1'b0;
  always #5 clk = ~clk;

  riscv_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_if ();
  riscv_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) upg_if ();
  riscv_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cpu1_if ();
  riscv_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) upg1_if ();

  logic          mem_en, mem_we, m1_en, m1_we;
  logic [3:0]    mem_be, m1_be;
  logic [AW-1:0] mem_addr, m1_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, m1_wdata, m1_rdata;

  riscv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_upg_active(upg_active),
    .io_cpu(cpu_if), .io_upg(upg_if),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_be(mem_be), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  riscv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut_l1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_upg_active(upg_active1),
    .io_cpu(cpu1_if), .io_upg(upg1_if),
    .o_mem_en(m1_en), .o_mem_we(m1_we), .o_mem_be(m1_be), .o_mem_addr(m1_addr),
    .o_mem_wdata(m1_wdata), .i_mem_rdata(m1_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, in absolute cycle numbers.
  int   t = 0;
  int   free_at = 0;
  int   resp_at = -1;
  logic resp_upg = 1'b0;
`ifdef MEM_ARB_RR_EN
  logic rr_last_upg = 1'b1;
`endif
  logic last_grant = 1'b0;
  logic last_win_u = 1'b0;
  logic obs_cpu_ready, obs_upg_ready;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, t);
    end
  endtask

  function automatic req_t mk(input logic rq, input logic we, input logic [3:0] be,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t r;
    r = {rq, we, be, a, d};
    return r;
  endfunction

  function automatic req_t rand_req(input int unsigned tenths);
    req_t        r;
    logic [31:0] tmp;
    tmp     = $urandom;
    r.req   = ($urandom_range(0, 9) < tenths);
    r.we    = tmp[31];
    r.be    = tmp[30:27];
    r.addr  = tmp[AW-1:0];
    r.wdata = $urandom;
    return r;
  endfunction

  task automatic run_cycle(input logic rst_v, input logic act, input req_t c, input req_t u);
    logic [DW-1:0] mrd;
    logic          elig_c, elig_u, grant, win_u, exp_crv, exp_urv;
    req_t          w;
    mrd = $urandom;
    @(posedge clk);
    #1;
    rst_n        = rst_v;
    upg_active   = act;
    cpu_if.req   = c.req;
    cpu_if.we    = c.we;
    cpu_if.be    = c.be;
    cpu_if.addr  = c.addr;
    cpu_if.wdata = c.wdata;
    upg_if.req   = u.req;
    upg_if.we    = u.we;
    upg_if.be    = u.be;
    upg_if.addr  = u.addr;
    upg_if.wdata = u.wdata;
    mem_rdata    = mrd;
    @(negedge clk);
    obs_cpu_ready = cpu_if.ready;
    obs_upg_ready = upg_if.ready;
    if (!rst_v) begin
      check_eq("reset_out", 64'({cpu_if.ready, upg_if.ready, mem_en, mem_we,
                                 cpu_if.rvalid, upg_if.rvalid}), 64'd0);
      resp_at    = -1;
      free_at    = t + 1;
      last_grant = 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_last_upg = 1'b1;
`endif
    end else begin
      exp_crv = (resp_at == t) && !resp_upg;
      exp_urv = (resp_at == t) && resp_upg;
      elig_c  = c.req && !act;
      elig_u  = u.req;
      grant   = (t >= free_at) && (elig_c || elig_u);
`ifdef MEM_ARB_RR_EN
      win_u   = elig_u && (!elig_c || !rr_last_upg);
`else
      win_u   = elig_u;
`endif
      check_eq("ctl", 64'({cpu_if.ready, upg_if.ready, mem_en, cpu_if.rvalid, upg_if.rvalid}),
               64'({grant && !win_u, grant && win_u, grant, exp_crv, exp_urv}));
      if (grant) begin
        w = win_u ? u : c;
        check_eq("mem_bus", 64'({mem_we, mem_be, mem_addr, mem_wdata}),
                 64'({w.we, w.be, w.addr, w.wdata}));
        resp_at  = t + LAT;
        free_at  = t + LAT + 1;
        resp_upg = win_u;
`ifdef MEM_ARB_RR_EN
        rr_last_upg = win_u;
`endif
      end
      if (exp_crv) check_eq("cpu_rdata", 64'(cpu_if.rdata), 64'(mrd));
      if (exp_urv) check_eq("upg_rdata", 64'(upg_if.rdata), 64'(mrd));
      last_grant = grant;
      last_win_u = win_u;
    end
    t++;
  endtask

  initial begin
    req_t       none, cc, uc;
    logic [3:0] order;
    int         k;
    logic       act, rst_v;

    none = '0;
    cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.be = '0; cpu_if.addr = '0; cpu_if.wdata = '0;
    upg_if.req = 1'b0; upg_if.we = 1'b0; upg_if.be = '0; upg_if.addr = '0; upg_if.wdata = '0;
    cpu1_if.req = 1'b0; cpu1_if.we = 1'b0; cpu1_if.be = '0; cpu1_if.addr = '0;
    cpu1_if.wdata = '0;
    upg1_if.req = 1'b0; upg1_if.we = 1'b0; upg1_if.be = '0; upg1_if.addr = '0;
    upg1_if.wdata = '0;
    mem_rdata = '0;
    m1_rdata  = '0;

    // Reset with requests present: nothing may be granted.
    run_cycle(1'b0, 1'b0, none, none);
    run_cycle(1'b0, 1'b0, mk(1, 0, 4'hF, 14'h001, 32'h0), mk(1, 1, 4'hF, 14'h002, 32'h1));

    // MEM_LAT=1 CPU read on the second instance.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cpu1_if.req = 1'b1; cpu1_if.we = 1'b0; cpu1_if.be = 4'hF; cpu1_if.addr = 14'h010;
    m1_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check_eq("l1_grant", 64'({cpu1_if.ready, m1_en, m1_we, m1_addr}), 64'({3'b110, 14'h010}));
    @(posedge clk);
    #1;
    cpu1_if.req = 1'b0;
    @(negedge clk);
    check_eq("l1_rvalid", 64'({cpu1_if.rvalid, cpu1_if.rdata}), 64'({1'b1, 32'hDEADBEEF}));
    check_eq("l1_busy", 64'({cpu1_if.ready, m1_en}), 64'd0);
    @(posedge clk);
    #1;
    cpu1_if.req = 1'b1; cpu1_if.addr = 14'h020;
    @(negedge clk);
    check_eq("l1_regrant", 64'({cpu1_if.ready, m1_en, cpu1_if.rvalid}), 64'(3'b110));
    @(posedge clk);
    #1;
    cpu1_if.req = 1'b0;
    t = free_at;

    // UPG write at the top address; CPU waiting must not be granted until T+LAT+1.
    run_cycle(1'b1, 1'b0, none, mk(1, 1, 4'hF, 14'h3FFF, 32'h12345678));
    for (int i = 0; i < LAT + 1; i++) run_cycle(1'b1, 1'b0, mk(1, 0, 4'h3, 14'h100, 32'h0), none);
    for (int i = 0; i < LAT + 1; i++) run_cycle(1'b1, 1'b0, none, none);

    // Both requesting continuously from reset: grant order.
    run_cycle(1'b0, 1'b0, none, none);
    cc = mk(1, 0, 4'hF, 14'h200, 32'h0);
    uc = mk(1, 1, 4'hF, 14'h300, 32'hA5A5A5A5);
    order = '0;
    k = 0;
    for (int i = 0; i < 4 * (LAT + 1); i++) begin
      run_cycle(1'b1, 1'b0, cc, uc);
      if (obs_cpu_ready || obs_upg_ready) begin
        if (k < 4) order[k] = obs_upg_ready;
        k++;
      end
      if (obs_cpu_ready) cc.addr = cc.addr + 14'd1;
      if (obs_upg_ready) uc.addr = uc.addr + 14'd1;
    end
`ifdef MEM_ARB_RR_EN
    check_eq("grant_order", 64'(order), 64'(4'b1010));
`else
    check_eq("grant_order", 64'(order), 64'(4'b1111));
`endif
    for (int i = 0; i < LAT + 1; i++) run_cycle(1'b1, 1'b0, none, none);

    // Lockout: CPU blocked while upg_active, granted the cycle it drops.
    for (int i = 0; i < 10; i++) run_cycle(1'b1, 1'b1, mk(1, 1, 4'h1, 14'h040, 32'h55), none);
    run_cycle(1'b1, 1'b0, mk(1, 1, 4'h1, 14'h040, 32'h55), none);
    check_eq("lockout_release", 64'(obs_cpu_ready), 64'd1);
    for (int i = 0; i < LAT + 1; i++) run_cycle(1'b1, 1'b0, none, none);

    // Reset one cycle into a CPU read: no response, fresh grant right after release.
    run_cycle(1'b1, 1'b0, mk(1, 0, 4'hF, 14'h080, 32'h0), none);
    run_cycle(1'b0, 1'b0, none, none);
    for (int i = 0; i < LAT + 1; i++) run_cycle(1'b1, 1'b0, none, none);
    run_cycle(1'b0, 1'b0, none, none);
    run_cycle(1'b1, 1'b0, mk(1, 0, 4'hF, 14'h081, 32'h0), none);
    check_eq("post_reset_grant", 64'(obs_cpu_ready), 64'd1);
    for (int i = 0; i < LAT + 1; i++) run_cycle(1'b1, 1'b0, none, none);

    // upg_active rises mid CPU transaction: response still arrives, then only UPG is served.
    run_cycle(1'b1, 1'b0, mk(1, 0, 4'hF, 14'h0C0, 32'h0), none);
    for (int i = 0; i < LAT; i++) run_cycle(1'b1, 1'b1, mk(1, 0, 4'hF, 14'h0C4, 32'h0), none);
    for (int i = 0; i < 2 * (LAT + 1); i++)
      run_cycle(1'b1, 1'b1, mk(1, 0, 4'hF, 14'h0C4, 32'h0), mk(1, 1, 4'hC, 14'h0C8, 32'h9));
    for (int i = 0; i < LAT + 1; i++) run_cycle(1'b1, 1'b0, none, none);

    // Random traffic with request holding, lockout toggling and occasional resets.
    cc  = none;
    uc  = none;
    act = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!cc.req || (last_grant && !last_win_u)) cc = rand_req(4);
      if (!uc.req || (last_grant && last_win_u))  uc = rand_req(3);
      if ($urandom_range(0, 19) == 0) act = ~act;
      rst_v = ($urandom_range(0, 99) != 0);
      run_cycle(rst_v, act, cc, uc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
